shift_deserializer: RTL and testbench

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

---
 rtl/shift_deserializer.sv | 121 ++++++++++++
 tb/tb_shift_deserializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: shifts ser_in into a WIDTH-bit word in either bit order
// and presents each completed word on A with a valid/ready handshake and a sticky overrun flag.
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             outValid_q, outValid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] srShifted;
  logic             wordDone;

  assign srShifted = dir_q ? {ser_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], ser_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      a_q        <= '0;
      outValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      a_q        <= a_d;
      outValid_q <= outValid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    a_d        = a_q;
    outValid_d = outValid_q;
    overrun_d  = overrun_q;
    wordDone   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d      = '0;
          cnt_d     = '0;
          dir_d     = dir;
          overrun_d = 1'b0;
          state_d   = RECV;
        end
      end
      RECV: begin
        // stop outranks start and also blocks a bit presented on the same edge
        if (stop) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (start) begin
          sr_d      = '0;
          cnt_d     = '0;
          dir_d     = dir;
          overrun_d = 1'b0;
        end else if (ser_valid) begin
          sr_d = srShifted;
          if (cnt_q == LAST_BIT) begin
            cnt_d    = '0;
            wordDone = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register and handshake run independently of the FSM state
    if (wordDone) begin
      a_d        = srShifted;
      outValid_d = 1'b1;
      if (outValid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  assign A         = a_q;
  assign out_valid = outValid_q;
  assign busy      = (state_q == RECV);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: a table of single-cycle vectors followed by
// hand-written sequences for handshake, stop/restart and asynchronous reset cases.
module tb_shift_deserializer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir;
  logic       serIn;
  logic       serValid;
  logic       outReady;
  logic [7:0] aOut;
  logic       outValid;
  logic       busy;
  logic       overrun;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic       dir;
    logic       serIn;
    logic       serValid;
    logic       outReady;
    logic [7:0] expA;
    logic       expValid;
    logic       expBusy;
    logic       expOverrun;
  } vec_t;

  vec_t vecs[$];

  shift_deserializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .ser_in    (serIn),
    .ser_valid (serValid),
    .out_ready (outReady),
    .A         (aOut),
    .out_valid (outValid),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic st, input logic sp, input logic d, input logic si,
                        input logic sv, input logic rdy, input logic [7:0] ea,
                        input logic ev, input logic eb, input logic eo);
    vec_t v;
    v.start = st; v.stop = sp; v.dir = d; v.serIn = si; v.serValid = sv; v.outReady = rdy;
    v.expA = ea; v.expValid = ev; v.expBusy = eb; v.expOverrun = eo;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge
  task automatic applyStimulus(input logic st, input logic sp, input logic d, input logic si,
                               input logic sv, input logic rdy);
    start = st; stop = sp; dir = d; serIn = si; serValid = sv; outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ea, input logic ev,
                             input logic eb, input logic eo);
    testCount++;
    if (aOut !== ea) begin
      failCount++;
      $display("[TB] FAIL %s A: got %02h expected %02h", name, aOut, ea);
    end
    testCount++;
    if (outValid !== ev) begin
      failCount++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", name, outValid, ev);
    end
    testCount++;
    if (busy !== eb) begin
      failCount++;
      $display("[TB] FAIL %s busy: got %b expected %b", name, busy, eb);
    end
    testCount++;
    if (overrun !== eo) begin
      failCount++;
      $display("[TB] FAIL %s overrun: got %b expected %b", name, overrun, eo);
    end
  endtask

  // Send a full MSB-first byte; out_ready is applied only on the final bit's edge
  task automatic sendByteMsb(input logic [7:0] w, input logic lastReady);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, w[7-i], 1'b1, (i == 7) ? lastReady : 1'b0);
    end
  endtask

  initial begin
    logic [7:0] b32;
    logic [7:0] b33;
    logic [7:0] w1;
    logic [7:0] w2;
    logic [4:0] part;
    logic       b;

    b32 = 8'hAA;
    b33 = 8'hF0;
    w1  = 8'h0F;
    w2  = 8'h3C;

    // Basic MSB-first word
    addVec(1, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      b = b32[7-i];
      addVec(0, 0, 0, b, 1, 0, (i == 7) ? 8'hAA : 8'h00, (i == 7), 1, 0);
    end
    addVec(0, 0, 0, 0, 0, 1, 8'hAA, 0, 1, 0);

    // LSB-first word with gaps; dir toggles mid-frame and gap cycles carry the opposite bit
    addVec(1, 0, 1, 0, 0, 0, 8'hAA, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      b = b33[i];
      addVec(0, 0, logic'(i % 2), b, 1, 0, (i == 7) ? 8'hF0 : 8'hAA, (i == 7), 1, 0);
      addVec(0, 0, 0, ~b, 0, 0, (i == 7) ? 8'hF0 : 8'hAA, (i == 7), 1, 0);
    end
    addVec(0, 0, 0, 0, 0, 1, 8'hF0, 0, 1, 0);

    // Back-to-back words without consumption overrun, then restart clears the flag
    addVec(1, 0, 0, 0, 0, 0, 8'hF0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      b = w1[7-i];
      addVec(0, 0, 0, b, 1, 0, (i == 7) ? 8'h0F : 8'hF0, (i == 7), 1, 0);
    end
    for (int i = 0; i < 8; i++) begin
      b = w2[7-i];
      addVec(0, 0, 0, b, 1, 0, (i == 7) ? 8'h3C : 8'h0F, 1, 1, (i == 7));
    end
    addVec(1, 0, 0, 0, 0, 0, 8'h3C, 1, 1, 0);

    rst = 1'b1; start = 0; stop = 0; dir = 0; serIn = 0; serValid = 0; outReady = 0;
    #12;
    checkOutput("reset", 8'h00, 0, 0, 0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].start, vecs[k].stop, vecs[k].dir, vecs[k].serIn,
                    vecs[k].serValid, vecs[k].outReady);
      checkOutput($sformatf("vec%0d", k), vecs[k].expA, vecs[k].expValid,
                  vecs[k].expBusy, vecs[k].expOverrun);
    end

    // Ready on the second completion edge: overwrite without overrun
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("consume3C", 8'h3C, 0, 1, 0);
    sendByteMsb(8'h0F, 1'b0);
    checkOutput("word0F", 8'h0F, 1, 1, 0);
    sendByteMsb(8'h3C, 1'b1);
    checkOutput("word3CReady", 8'h3C, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("consumeAfter", 8'h3C, 0, 1, 0);

    // Partial word then stop, with a bit offered on the stop edge
    part = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, part[4-i], 1, 0);
    end
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("stopPartial", 8'h3C, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, (i == 1), 0, 1, 1, 0);
    end
    checkOutput("idleIgnores", 8'h3C, 0, 0, 0);

    // Seven bits then stop with the eighth bit: it must not complete a word
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
    end
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("stopBlocksBit", 8'h3C, 0, 0, 0);

    // stop and start together: stop wins
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 0, 1, 1, 0);
    checkOutput("stopOverStart", 8'h3C, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 0, 0);
    sendByteMsb(8'h81, 1'b0);
    checkOutput("word81", 8'h81, 1, 1, 0);

    // Handshake still works in IDLE
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("stopKeepsValid", 8'h81, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("idleConsume", 8'h81, 0, 0, 0);

    // Asynchronous reset between edges after three bits
    applyStimulus(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
    end
    checkOutput("preReset", 8'h81, 0, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", 8'h00, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
    end
    checkOutput("noStartAfterReset", 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
